// File: rtl/nap_pkg.sv
// Shared definitions for the nap countdown core: state encoding, BCD digit
// positions within the packed HH:MM:SS word, and digit limits.
package nap_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReady = 3'd1,
    StRun   = 3'd2,
    StPause = 3'd3,
    StAlarm = 3'd4
  } state_e;

  // Word layout is {H10, H1, M10, M1, S10, S1}, one nibble each
  localparam int unsigned S1Lsb  = 0;
  localparam int unsigned S10Lsb = 4;
  localparam int unsigned M1Lsb  = 8;
  localparam int unsigned M10Lsb = 12;
  localparam int unsigned H1Lsb  = 16;
  localparam int unsigned H10Lsb = 20;

  localparam logic [3:0] DigitMax = 4'd9;
  localparam logic [3:0] TensMax  = 4'd5;
  localparam logic [7:0] HourMax  = 8'd23;

endpackage

// File: rtl/nap_countdown_core_dec.sv
// Combinational BCD HH:MM:SS one-second decrementer with zero and validity
// flags; shared by the countdown datapath and load checking.
module bcd_time_dec
  import nap_pkg::*;
(
  input  logic [23:0] i_time,
  output logic [23:0] o_time,
  output logic        o_is_zero,
  output logic        o_is_valid
);

  logic [3:0] w_s1, w_s10, w_m1, w_m10, w_h1, w_h10;
  logic       w_b_s1, w_b_s10, w_b_m1, w_b_m10, w_b_h1;
  logic [7:0] w_hours;

  assign w_s1  = i_time[S1Lsb  +: 4];
  assign w_s10 = i_time[S10Lsb +: 4];
  assign w_m1  = i_time[M1Lsb  +: 4];
  assign w_m10 = i_time[M10Lsb +: 4];
  assign w_h1  = i_time[H1Lsb  +: 4];
  assign w_h10 = i_time[H10Lsb +: 4];

  // Borrow ripples upward while each lower digit sits at zero
  assign w_b_s1  = (w_s1 == 4'd0);
  assign w_b_s10 = w_b_s1  && (w_s10 == 4'd0);
  assign w_b_m1  = w_b_s10 && (w_m1  == 4'd0);
  assign w_b_m10 = w_b_m1  && (w_m10 == 4'd0);
  assign w_b_h1  = w_b_m10 && (w_h1  == 4'd0);

  always_comb begin
    o_time = i_time;
    o_time[S1Lsb +: 4] = w_b_s1 ? DigitMax : w_s1 - 4'd1;
    if (w_b_s1)  o_time[S10Lsb +: 4] = (w_s10 == 4'd0) ? TensMax  : w_s10 - 4'd1;
    if (w_b_s10) o_time[M1Lsb  +: 4] = (w_m1  == 4'd0) ? DigitMax : w_m1  - 4'd1;
    if (w_b_m1)  o_time[M10Lsb +: 4] = (w_m10 == 4'd0) ? TensMax  : w_m10 - 4'd1;
    if (w_b_m10) o_time[H1Lsb  +: 4] = (w_h1  == 4'd0) ? DigitMax : w_h1  - 4'd1;
    if (w_b_h1)  o_time[H10Lsb +: 4] = w_h10 - 4'd1;
  end

  assign w_hours   = ({4'd0, w_h10} * 8'd10) + {4'd0, w_h1};
  assign o_is_zero = (i_time == 24'd0);

  assign o_is_valid = (w_s1 <= DigitMax) && (w_s10 <= TensMax) &&
                      (w_m1 <= DigitMax) && (w_m10 <= TensMax) &&
                      (w_h1 <= DigitMax) && (w_h10 <= DigitMax) &&
                      (w_hours <= HourMax) && !o_is_zero;

endmodule

// File: rtl/nap_countdown_core.sv
// BCD HH:MM:SS countdown engine with one-second tick divider, pause/resume,
// bounded snooze re-arm and a self-expiring alarm phase.
module nap_countdown_core
  import nap_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 50000000,
  parameter int unsigned SNOOZE_MIN      = 5,
  parameter int unsigned MAX_SNOOZE      = 3,
  parameter int unsigned ALARM_TIMEOUT_S = 60
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic [23:0] i_load_time,
  input  logic        i_start,
  input  logic        i_pause,
  input  logic        i_snooze,
  input  logic        i_cancel,
  output logic [23:0] o_time_out,
  output logic [2:0]  o_state,
  output logic        o_alarm,
  output logic        o_complete,
  output logic        o_load_err,
  output logic        o_expired,
  output logic [3:0]  o_snooze_left
);

  localparam int unsigned TickW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [23:0] SnoozeTime = {8'h00, 4'(SNOOZE_MIN / 10), 4'(SNOOZE_MIN % 10), 8'h00};

  state_e             r_state, w_state_d;
  logic [23:0]        r_time, w_time_d;
  logic [TickW-1:0]   r_tick, w_tick_d;
  logic [7:0]         r_alarm_s, w_alarm_s_d;
  logic [3:0]         r_snooze_left, w_snooze_left_d;
  logic               r_alarm, r_complete, r_load_err, r_expired;
  logic               w_complete_d, w_load_err_d, w_expired_d, w_take_load;
  logic               w_tick_wrap;
  logic [23:0]        w_dec_time, w_ld_dec_unused;
  logic               w_load_valid, w_dec_zero_unused, w_dec_valid_unused, w_ld_zero_unused;

  bcd_time_dec u_run_dec (
    .i_time     (r_time),
    .o_time     (w_dec_time),
    .o_is_zero  (w_dec_zero_unused),
    .o_is_valid (w_dec_valid_unused)
  );

  bcd_time_dec u_load_chk (
    .i_time     (i_load_time),
    .o_time     (w_ld_dec_unused),
    .o_is_zero  (w_ld_zero_unused),
    .o_is_valid (w_load_valid)
  );

  assign w_tick_wrap = (r_tick == TickW'(TICK_DIV - 1));

  always_comb begin
    w_state_d       = r_state;
    w_time_d        = r_time;
    w_tick_d        = r_tick;
    w_alarm_s_d     = r_alarm_s;
    w_snooze_left_d = r_snooze_left;
    w_complete_d    = 1'b0;
    w_load_err_d    = 1'b0;
    w_expired_d     = 1'b0;
    w_take_load     = 1'b0;

    if (i_cancel) begin
      w_state_d       = StIdle;
      w_time_d        = 24'd0;
      w_tick_d        = '0;
      w_alarm_s_d     = 8'd0;
      w_snooze_left_d = 4'(MAX_SNOOZE);
    end else begin
      unique case (r_state)
        StIdle: w_take_load = i_load;
        StReady, StPause: begin
          if (i_start) begin
            w_state_d = StRun;
            if (r_state == StReady) w_tick_d = '0;
          end else begin
            w_take_load = i_load;
          end
        end
        StRun: begin
          if (i_pause) begin
            w_state_d = StPause;
          end else if (w_tick_wrap) begin
            w_tick_d = '0;
            w_time_d = w_dec_time;
            if (w_dec_time == 24'd0) begin
              w_state_d    = StAlarm;
              w_complete_d = 1'b1;
              w_alarm_s_d  = 8'd0;
            end
          end else begin
            w_tick_d = r_tick + TickW'(1);
          end
        end
        StAlarm: begin
          if (i_snooze && (r_snooze_left != 4'd0)) begin
            w_state_d       = StRun;
            w_time_d        = SnoozeTime;
            w_tick_d        = '0;
            w_snooze_left_d = r_snooze_left - 4'd1;
          end else if (w_tick_wrap) begin
            w_tick_d = '0;
            if (r_alarm_s == 8'(ALARM_TIMEOUT_S - 1)) begin
              w_state_d       = StIdle;
              w_expired_d     = 1'b1;
              w_alarm_s_d     = 8'd0;
              w_snooze_left_d = 4'(MAX_SNOOZE);
            end else begin
              w_alarm_s_d = r_alarm_s + 8'd1;
            end
          end else begin
            w_tick_d = r_tick + TickW'(1);
          end
        end
        default: w_state_d = StIdle;
      endcase

      // A valid load in PAUSE keeps the session paused with a fresh second
      if (w_take_load) begin
        if (w_load_valid) begin
          w_time_d  = i_load_time;
          w_tick_d  = '0;
          w_state_d = (r_state == StPause) ? StPause : StReady;
        end else begin
          w_load_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_time        <= 24'd0;
      r_tick        <= '0;
      r_alarm_s     <= 8'd0;
      r_snooze_left <= 4'(MAX_SNOOZE);
      r_alarm       <= 1'b0;
      r_complete    <= 1'b0;
      r_load_err    <= 1'b0;
      r_expired     <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_time        <= w_time_d;
      r_tick        <= w_tick_d;
      r_alarm_s     <= w_alarm_s_d;
      r_snooze_left <= w_snooze_left_d;
      r_alarm       <= (w_state_d == StAlarm);
      r_complete    <= w_complete_d;
      r_load_err    <= w_load_err_d;
      r_expired     <= w_expired_d;
    end
  end

  assign o_time_out    = r_time;
  assign o_state       = r_state;
  assign o_alarm       = r_alarm;
  assign o_complete    = r_complete;
  assign o_load_err    = r_load_err;
  assign o_expired     = r_expired;
  assign o_snooze_left = r_snooze_left;

endmodule

// File: tb/tb_nap_countdown_core.sv
// Bench for nap_countdown_core: directed scenarios plus random commands, all
// checked against a seconds-based reference model every cycle.
module tb_nap_countdown_core;

  localparam int unsigned TD = 4;
  localparam int unsigned SM = 1;
  localparam int unsigned MS = 1;
  localparam int unsigned AT = 3;

  localparam int MIdle = 0, MReady = 1, MRun = 2, MPause = 3, MAlarm = 4;

  logic        clk = 1'b0;
  logic        rst, ld, st, ps, sn, cn;
  logic [23:0] ltime;
  logic [23:0] time_out;
  logic [2:0]  state;
  logic        alarm, complete, load_err, expired;
  logic [3:0]  snooze_left;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining time kept as plain seconds
  int m_state, m_secs, m_tick, m_alarm_s, m_snz;
  bit m_cmp, m_err, m_exp;

  always #5 clk = ~clk;

  nap_countdown_core #(
    .TICK_DIV        (TD),
    .SNOOZE_MIN      (SM),
    .MAX_SNOOZE      (MS),
    .ALARM_TIMEOUT_S (AT)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_load        (ld),
    .i_load_time   (ltime),
    .i_start       (st),
    .i_pause       (ps),
    .i_snooze      (sn),
    .i_cancel      (cn),
    .o_time_out    (time_out),
    .o_state       (state),
    .o_alarm       (alarm),
    .o_complete    (complete),
    .o_load_err    (load_err),
    .o_expired     (expired),
    .o_snooze_left (snooze_left)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int secs);
    int h, m, s;
    h = secs / 3600;
    m = (secs / 60) % 60;
    s = secs % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int bcd_secs(input logic [23:0] t, output bit ok);
    int d[6];
    int secs;
    for (int i = 0; i < 6; i++) d[i] = int'(t[i*4 +: 4]);
    secs = (d[5] * 10 + d[4]) * 3600 + (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
    ok = 1'b1;
    for (int i = 0; i < 6; i++) if (d[i] > 9) ok = 1'b0;
    if (d[1] > 5 || d[3] > 5 || (d[5] * 10 + d[4]) > 23 || secs == 0) ok = 1'b0;
    return secs;
  endfunction

  task automatic model_step();
    bit ok;
    int v;
    bit take_load;
    m_cmp = 0; m_err = 0; m_exp = 0;
    take_load = 0;
    if (rst) begin
      m_state = MIdle; m_secs = 0; m_tick = 0; m_alarm_s = 0; m_snz = MS;
    end else if (cn) begin
      m_state = MIdle; m_secs = 0; m_tick = 0; m_alarm_s = 0; m_snz = MS;
    end else begin
      case (m_state)
        MIdle: take_load = ld;
        MReady, MPause: begin
          if (st) begin
            if (m_state == MReady) m_tick = 0;
            m_state = MRun;
          end else take_load = ld;
        end
        MRun: begin
          if (ps) m_state = MPause;
          else if (m_tick == TD - 1) begin
            m_tick = 0;
            m_secs = m_secs - 1;
            if (m_secs == 0) begin m_state = MAlarm; m_cmp = 1; m_alarm_s = 0; end
          end else m_tick++;
        end
        MAlarm: begin
          if (sn && m_snz > 0) begin
            m_secs = SM * 60; m_snz--; m_state = MRun; m_tick = 0;
          end else if (m_tick == TD - 1) begin
            m_tick = 0;
            m_alarm_s++;
            if (m_alarm_s == AT) begin
              m_state = MIdle; m_exp = 1; m_alarm_s = 0; m_snz = MS;
            end
          end else m_tick++;
        end
        default: m_state = MIdle;
      endcase
      if (take_load) begin
        v = bcd_secs(ltime, ok);
        if (ok) begin
          m_secs = v; m_tick = 0;
          if (m_state != MPause) m_state = MReady;
        end else m_err = 1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_eq("state", 32'(state), 32'(m_state));
    check_eq("time_out", 32'(time_out), 32'(to_bcd(m_secs)));
    check_eq("alarm", 32'(alarm), 32'(m_state == MAlarm));
    check_eq("complete", 32'(complete), 32'(m_cmp));
    check_eq("load_err", 32'(load_err), 32'(m_err));
    check_eq("expired", 32'(expired), 32'(m_exp));
    check_eq("snooze_left", 32'(snooze_left), 32'(m_snz));
    rst = 0; ld = 0; st = 0; ps = 0; sn = 0; cn = 0;
  endtask

  task automatic do_load(input logic [23:0] t);
    ld = 1; ltime = t; cycle();
  endtask

  task automatic do_start();
    st = 1; cycle();
  endtask

  task automatic do_cancel();
    cn = 1; cycle();
  endtask

  initial begin
    rst = 1; ld = 0; st = 0; ps = 0; sn = 0; cn = 0; ltime = 24'd0;
    m_state = MIdle; m_secs = 0; m_tick = 0; m_alarm_s = 0; m_snz = MS;
    cycle();
    check_eq("reset_state", 32'(state), 32'd0);
    check_eq("reset_snz", 32'(snooze_left), 32'(MS));

    // Borrow across minutes, then steady seconds countdown
    do_load(24'h000100);
    do_start();
    repeat (4) cycle();
    check_eq("borrow_first_tick", 32'(time_out), 32'h000059);
    repeat (12) cycle();
    check_eq("after_4_ticks", 32'(time_out), 32'h000056);
    repeat (4) cycle();
    check_eq("after_5_ticks", 32'(time_out), 32'h000055);
    do_cancel();

    // Reach zero, alarm, then auto-expire
    do_load(24'h000002);
    do_start();
    repeat (8) cycle();
    check_eq("alarm_state", 32'(state), 32'd4);
    check_eq("alarm_on", 32'(alarm), 32'd1);
    check_eq("complete_pulse", 32'(complete), 32'd1);
    repeat (12) cycle();
    check_eq("expired_state", 32'(state), 32'd0);
    check_eq("expired_pulse", 32'(expired), 32'd1);
    cycle();
    check_eq("expired_drop", 32'(expired), 32'd0);

    // Snooze once, then the exhausted snooze is ignored
    do_load(24'h000001);
    do_start();
    repeat (4) cycle();
    sn = 1; cycle();
    check_eq("snooze_time", 32'(time_out), 32'h000100);
    check_eq("snooze_left0", 32'(snooze_left), 32'd0);
    check_eq("snooze_run", 32'(state), 32'd2);
    repeat (240) cycle();
    check_eq("second_alarm", 32'(state), 32'd4);
    sn = 1; cycle();
    check_eq("snooze_ignored", 32'(alarm), 32'd1);
    do_cancel();

    // Rejected loads
    do_load(24'h126000);
    check_eq("err_min", 32'(load_err), 32'd1);
    do_load(24'h240000);
    check_eq("err_hour", 32'(load_err), 32'd1);
    do_load(24'h000000);
    check_eq("err_zero", 32'(load_err), 32'd1);
    check_eq("err_time", 32'(time_out), 32'd0);
    check_eq("err_state", 32'(state), 32'd0);

    // Pause keeps the partial second
    do_load(24'h010000);
    do_start();
    repeat (2) cycle();
    ps = 1; cycle();
    repeat (10) cycle();
    do_start();
    repeat (2) cycle();
    check_eq("pause_resume", 32'(time_out), 32'h005959);
    do_cancel();

    // Cancel beats snooze; reset in alarm
    do_load(24'h000030);
    do_start();
    repeat (6) cycle();
    cn = 1; sn = 1; cycle();
    check_eq("cancel_state", 32'(state), 32'd0);
    check_eq("cancel_time", 32'(time_out), 32'd0);
    check_eq("cancel_nocomplete", 32'(complete), 32'd0);
    do_load(24'h000001);
    do_start();
    repeat (4) cycle();
    rst = 1; cycle();
    check_eq("rst_alarm", 32'(alarm), 32'd0);
    check_eq("rst_state", 32'(state), 32'd0);

    // Random command mix
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        ld = 1;
        case ($urandom_range(0, 3))
          0, 1: ltime = to_bcd(int'($urandom_range(1, 12)));
          2:    ltime = to_bcd(int'($urandom_range(0, 86399)));
          default: ltime = 24'($urandom);
        endcase
      end
      st  = ($urandom_range(0, 5) == 0);
      ps  = ($urandom_range(0, 11) == 0);
      sn  = ($urandom_range(0, 9) == 0);
      cn  = ($urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
